// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_t;

  localparam int INSTR_WIDTH = 32;
  localparam int PC_INC      = 4;

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: single-outstanding imem requests, one-entry
// decode buffer, and redirect handling that drains any stale in-flight response.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_VECTOR  = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] pc,
  output logic [ADDRESS_WIDTH-1:0] pc_next,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_target,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [INSTR_WIDTH-1:0]   imem_rdata,
  output logic                     instr_valid,
  output logic [INSTR_WIDTH-1:0]   instr,
  output logic [ADDRESS_WIDTH-1:0] instr_pc,
  input  logic                     instr_ready
);

  localparam logic [ADDRESS_WIDTH-1:0] INC_AW   = ADDRESS_WIDTH'(PC_INC);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_AW = ~ADDRESS_WIDTH'(3);

  fetch_state_t             state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [INSTR_WIDTH-1:0]   instr_q, instr_d;
  logic [ADDRESS_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                     instr_valid_q, instr_valid_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      req_pc_q      <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_pc_q      <= req_pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_next       = pc;
    imem_req      = 1'b0;
    req_pc_d      = req_pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    case (state_q)
      IDLE: begin
        pc_next = RESET_VECTOR;
        state_d = REQ;
      end
      REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          req_pc_d = pc;
          pc_next  = pc + INC_AW;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_pc_d    = req_pc_q;
          instr_valid_d = 1'b1;
          state_d       = HOLD;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = REQ;
        end
      end
      DRAIN: begin
        if (imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything; a response already in flight must be drained.
    if (redirect_valid) begin
      pc_next       = redirect_target & ALIGN_AW;
      instr_valid_d = 1'b0;
      instr_d       = instr_q;
      instr_pc_d    = instr_pc_q;
      case (state_q)
        REQ:     state_d = imem_gnt    ? DRAIN : REQ;
        WAIT:    state_d = imem_rvalid ? REQ   : DRAIN;
        DRAIN:   state_d = imem_rvalid ? REQ   : DRAIN;
        default: state_d = REQ;
      endcase
    end
  end

  assign imem_addr   = pc;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the RISC-V core. It drives `pc_next` into the `pc` register, issues single-outstanding requests to instruction memory, and buffers each returned instruction until decode accepts it. It also applies branch/jump redirects from execute and discards any in-flight stale fetch. It sits between the `pc` register, the instruction-memory port and the decode stage.

## Interface
- `ADDRESS_WIDTH`, 32: PC and memory address width.
- `RESET_VECTOR`, 0: first fetch address after reset.

- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `pc`  in  ADDRESS_WIDTH  current PC from the `pc` register, which loads `pc_next` every cycle.
- `pc_next`  out  ADDRESS_WIDTH  next PC to the `pc` register; combinational.
- `redirect_valid`  in  1  execute-stage branch/jump taken.
- `redirect_target`  in  ADDRESS_WIDTH  redirect address; bits [1:0] are ignored and forced to 0.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  ADDRESS_WIDTH  request address; equals `pc`.
- `imem_gnt`  in  1  request accepted this cycle.
- `imem_rvalid`  in  1  response data valid.
- `imem_rdata`  in  32  response instruction.
- `instr_valid`  out  1  buffered instruction available to decode.
- `instr`  out  32  buffered instruction.
- `instr_pc`  out  ADDRESS_WIDTH  address of `instr`.
- `instr_ready`  in  1  decode accepts `instr`.

## Operation
- **States:** IDLE, REQ, WAIT, HOLD, DRAIN.
- **Default:** `pc_next = pc`. The PC holds unless one of the rules below changes it.
- **IDLE:** `pc_next = RESET_VECTOR`. Moves to REQ unconditionally.
- **REQ:** `imem_req = 1`.
  - On `imem_gnt`: latch `req_pc <= pc`, set `pc_next = pc + 4`, go to WAIT.
  - An ungranted request may change address (on redirect). Memory samples `imem_addr` only on `imem_gnt`.
- **WAIT:** `imem_req = 0`.
  - On `imem_rvalid`: load `instr <= imem_rdata` and `instr_pc <= req_pc`, set `instr_valid <= 1`, go to HOLD.
- **HOLD:** `instr`, `instr_pc` and `instr_valid` are stable.
  - On `instr_ready`: clear `instr_valid`, go to REQ.
- **DRAIN:** waits for the stale response.
  - On `imem_rvalid`: discard the data, go to REQ.
- **Redirect** (`redirect_valid = 1`) has priority over every other event in every state:
  - `pc_next = {redirect_target[AW-1:2], 2'b00}`.
  - `instr_valid` clears on the next edge.
  - Next state:
    - IDLE, HOLD → REQ.
    - REQ without `imem_gnt` → REQ.
    - REQ with same-cycle `imem_gnt` → DRAIN.
    - WAIT without `imem_rvalid` → DRAIN.
    - WAIT with same-cycle `imem_rvalid` → REQ; the data is discarded.
    - DRAIN → DRAIN, unless `imem_rvalid` in the same cycle, then REQ.
- **Ignored inputs:** `imem_rvalid` outside WAIT/DRAIN; `imem_gnt` outside REQ.
- **Arithmetic:** `pc + 4` wraps modulo 2^ADDRESS_WIDTH.
- **Reset:** asynchronous, at any time. State goes to IDLE; `instr_valid`, `instr`, `instr_pc` and `req_pc` go to 0; `imem_req` goes to 0. The outstanding fetch is abandoned. The memory is reset on the same `rst`.

## Timing
- **Outputs during and right after reset:** `imem_req = 0`, `instr_valid = 0`, `pc_next = RESET_VECTOR`.
- **First edge after reset release:** `pc` loads RESET_VECTOR and the state enters REQ. `imem_req` is high in the following cycle.
- **Grant and response:** grant can come in the first REQ cycle. `imem_rvalid` earliest is the cycle after the grant.
- **Decode handoff:** `instr_valid` rises the cycle after `imem_rvalid`.
- **Best-case throughput:** one instruction per 3 cycles (REQ → WAIT → HOLD → REQ) with zero-wait memory and `instr_ready = 1`.
- **Redirect latency:**
  - `pc` holds the target one edge after `redirect_valid`.
  - The first request to the target issues that next cycle from REQ, or after the stale `imem_rvalid` from DRAIN.
- **Registered outputs:** `instr_valid`, `instr`, `instr_pc`. All other outputs are combinational from state and inputs.

## Structure
- **Package `fetch_pkg`:**
  - `fetch_state_t` enum (IDLE, REQ, WAIT, HOLD, DRAIN).
  - `INSTR_WIDTH = 32`.
  - `PC_INC = 4`.
- **Composition:** single module. No sub-module is required; the `pc` register stays external and is instantiated alongside in the fetch stage top.

## Test plan
- **Reset and steady fetch:** release reset with `imem_gnt = 1`, one-cycle `imem_rvalid`, `instr_ready = 1`, rdata `0x00500093`. Expect `imem_addr 0x0`, then `instr_valid` with `instr_pc 0x0`, then `imem_addr 0x4` exactly 3 cycles after the first request.
- **Decode stall:** hold `instr_ready = 0` for 5 cycles in HOLD. Expect `instr`/`instr_pc` unchanged, `imem_req = 0`, `pc` held at `0x4`. On release, the next request goes to `0x4`.
- **Redirect in WAIT:** `redirect_valid` with target `0x100`, then stale rvalid `0xDEADBEEF`. Expect no `instr_valid` for the stale data, next `imem_addr 0x100`, delivered `instr_pc 0x100`.
- **Redirect with same-cycle grant:** target `0x203` in REQ together with `imem_gnt`. Expect DRAIN, one stale rvalid dropped, next `imem_addr 0x200`.
- **Wrap-around:** `RESET_VECTOR = 0xFFFFFFFC`. After that fetch is granted, expect `pc 0x00000000`.
- **Asynchronous reset mid-HOLD:** assert `rst`. Expect `instr_valid` to fall with no clock edge and `pc_next = RESET_VECTOR`. A later `imem_rvalid` while in IDLE/REQ is ignored.
